// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Arbitrates the single-port data memory between the CPU datapath and a
//   DMA/peripheral master. Each access runs for WAIT+1 ACCESS cycles and is
//   followed by one RESP cycle, in which the result is presented. Simultaneous
//   requests are resolved round-robin against the previous owner.
//
// Ports
//   CLK, RSTn                 clock (rising edge), async active-low reset
//   cpu_rd, cpu_wr            CPU level requests (write wins if both high)
//   cpu_addr, cpu_wdata       CPU address / write data
//   cpu_rdata                 registered CPU read data
//   cpu_stall                 CPU must hold its state and request
//   dma_req, dma_we           DMA level request, write(1)/read(0)
//   dma_addr, dma_wdata       DMA address / write data
//   dma_rdata                 registered DMA read data
//   dma_ack                   one-cycle DMA completion pulse
//   mem_en, mem_we            memory enable / write enable
//   mem_addr, mem_wdata       memory address / write data
//   mem_rdata                 memory read data, valid in final ACCESS cycle
//   busy                      FSM is not idle
module mem_bus_arbiter #(
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 16,
  parameter int unsigned WAIT = 1
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  owner_t          last_q, last_d;
  owner_t          grant;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
  logic            cpu_req;

  assign cpu_req = cpu_rd | cpu_wr;

  // On a tie the master that did not own the bus last time wins.
  always_comb begin
    grant = OWN_CPU;
    if (cpu_req && dma_req) begin
      grant = (last_q == OWN_DMA) ? OWN_CPU : OWN_DMA;
    end else if (dma_req) begin
      grant = OWN_DMA;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          state_d = S_ACCESS;
          owner_d = grant;
          last_d  = grant;
          cnt_d   = '0;
          if (grant == OWN_CPU) begin
            we_d    = cpu_wr;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end else begin
            we_d    = dma_we;
            addr_d  = dma_addr;
            wdata_d = dma_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == WAIT_C) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
            else                    dma_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_DMA;
      last_q      <= OWN_DMA;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = (state_q == S_ACCESS) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ack   = (state_q == S_RESP) & (owner_q == OWN_DMA);
  assign busy      = (state_q != S_IDLE);
  // Combinational from the request so a new CPU access stalls immediately.
  assign cpu_stall = cpu_req & ~((state_q == S_RESP) & (owner_q == OWN_CPU));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0, dma_wdata = '0;
  logic [15:0] mem_rdata = '0;

  logic [15:0] cpu_rdata_0, dma_rdata_0, mem_addr_0, mem_wdata_0;
  logic        cpu_stall_0, dma_ack_0, mem_en_0, mem_we_0, busy_0;
  logic [15:0] cpu_rdata_1, dma_rdata_1, mem_addr_1, mem_wdata_1;
  logic        cpu_stall_1, dma_ack_1, mem_en_1, mem_we_1, busy_1;
  logic [15:0] cpu_rdata_3, dma_rdata_3, mem_addr_3, mem_wdata_3;
  logic        cpu_stall_3, dma_ack_3, mem_en_3, mem_we_3, busy_3;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  mem_bus_arbiter #(.AW(16), .DW(16), .WAIT(0)) u0 (
    .CLK(CLK), .RSTn(RSTn), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_0),
    .cpu_stall(cpu_stall_0), .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata_0),
    .dma_ack(dma_ack_0), .mem_en(mem_en_0), .mem_we(mem_we_0),
    .mem_addr(mem_addr_0), .mem_wdata(mem_wdata_0), .mem_rdata(mem_rdata),
    .busy(busy_0)
  );

  mem_bus_arbiter #(.AW(16), .DW(16), .WAIT(1)) u1 (
    .CLK(CLK), .RSTn(RSTn), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_1),
    .cpu_stall(cpu_stall_1), .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata_1),
    .dma_ack(dma_ack_1), .mem_en(mem_en_1), .mem_we(mem_we_1),
    .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata),
    .busy(busy_1)
  );

  mem_bus_arbiter #(.AW(16), .DW(16), .WAIT(3)) u3 (
    .CLK(CLK), .RSTn(RSTn), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_3),
    .cpu_stall(cpu_stall_3), .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata_3),
    .dma_ack(dma_ack_3), .mem_en(mem_en_3), .mem_we(mem_we_3),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata),
    .busy(busy_3)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
  endtask

  // Leaves the caller in a fresh IDLE cycle, ready to drive cycle 0.
  task automatic do_reset();
    cyc();
    RSTn = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    RSTn = 1'b1;
  endtask

  initial begin
    do_reset();
    #1;
    chk1 ("rst_busy",      busy_1,      1'b0);
    chk1 ("rst_mem_en",    mem_en_1,    1'b0);
    chk1 ("rst_dma_ack",   dma_ack_1,   1'b0);
    chk1 ("rst_stall",     cpu_stall_1, 1'b0);
    chk16("rst_cpu_rdata", cpu_rdata_1, 16'h0000);
    chk16("rst_dma_rdata", dma_rdata_1, 16'h0000);

    // Single CPU read, WAIT=1
    cpu_rd = 1'b1; cpu_addr = 16'h0010; mem_rdata = 16'hBEEF;
    #1;
    chk1("rd_c0_stall", cpu_stall_1, 1'b1);
    chk1("rd_c0_en",    mem_en_1,    1'b0);
    cyc(); #1;
    chk1 ("rd_c1_en",    mem_en_1,    1'b1);
    chk1 ("rd_c1_we",    mem_we_1,    1'b0);
    chk16("rd_c1_addr",  mem_addr_1,  16'h0010);
    chk1 ("rd_c1_stall", cpu_stall_1, 1'b1);
    cyc(); #1;
    chk1("rd_c2_en",    mem_en_1,    1'b1);
    chk1("rd_c2_stall", cpu_stall_1, 1'b1);
    cyc(); #1;
    chk1 ("rd_c3_stall", cpu_stall_1, 1'b0);
    chk1 ("rd_c3_en",    mem_en_1,    1'b0);
    chk16("rd_c3_rdata", cpu_rdata_1, 16'hBEEF);
    cyc();
    cpu_rd = 1'b0;
    #1;
    chk1 ("rd_c4_busy",  busy_1,      1'b0);
    chk16("rd_c4_rdata", cpu_rdata_1, 16'hBEEF);

    // DMA read then DMA write, WAIT=0
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300; mem_rdata = 16'h5A5A;
    cyc(); #1;
    chk1("dr_c1_en", mem_en_0, 1'b1);
    cyc(); #1;
    chk1 ("dr_c2_ack",   dma_ack_0,   1'b1);
    chk16("dr_c2_rdata", dma_rdata_0, 16'h5A5A);
    cyc();
    dma_req = 1'b0;
    cyc();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 16'h1234;
    mem_rdata = 16'hFFFF;
    #1;
    chk1("dw_c0_ack", dma_ack_0, 1'b0);
    cyc(); #1;
    chk1 ("dw_c1_en",    mem_en_0,    1'b1);
    chk1 ("dw_c1_we",    mem_we_0,    1'b1);
    chk16("dw_c1_addr",  mem_addr_0,  16'h0200);
    chk16("dw_c1_wdata", mem_wdata_0, 16'h1234);
    chk1 ("dw_c1_ack",   dma_ack_0,   1'b0);
    cyc(); #1;
    chk1 ("dw_c2_ack",   dma_ack_0,   1'b1);
    chk1 ("dw_c2_en",    mem_en_0,    1'b0);
    chk16("dw_c2_rdata", dma_rdata_0, 16'h5A5A);
    cyc();
    dma_req = 1'b0;
    #1;
    chk1("dw_c3_ack",  dma_ack_0, 1'b0);
    chk1("dw_c3_busy", busy_0,    1'b0);

    // Tie after reset, WAIT=1
    do_reset();
    cpu_rd = 1'b1; cpu_addr = 16'h0040;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0400; mem_rdata = 16'h1111;
    cyc(); #1;
    chk1 ("tie_c1_en",   mem_en_1,   1'b1);
    chk16("tie_c1_addr", mem_addr_1, 16'h0040);
    cyc(); #1;
    chk16("tie_c2_addr", mem_addr_1, 16'h0040);
    cyc(); #1;
    chk1 ("tie_c3_stall", cpu_stall_1, 1'b0);
    chk16("tie_c3_rdata", cpu_rdata_1, 16'h1111);
    chk1 ("tie_c3_ack",   dma_ack_1,   1'b0);
    cyc();
    cpu_addr = 16'h0044; mem_rdata = 16'h2222;
    #1;
    chk1("tie_c4_busy",  busy_1,      1'b0);
    chk1("tie_c4_stall", cpu_stall_1, 1'b1);
    cyc(); #1;
    chk1 ("tie_c5_en",   mem_en_1,   1'b1);
    chk16("tie_c5_addr", mem_addr_1, 16'h0400);
    cyc(); #1;
    chk16("tie_c6_addr", mem_addr_1, 16'h0400);
    chk1 ("tie_c6_ack",  dma_ack_1,  1'b0);
    cyc(); #1;
    chk1 ("tie_c7_ack",   dma_ack_1,   1'b1);
    chk16("tie_c7_rdata", dma_rdata_1, 16'h2222);
    chk16("tie_c7_cpu",   cpu_rdata_1, 16'h1111);
    chk1 ("tie_c7_stall", cpu_stall_1, 1'b1);
    cyc();
    dma_req = 1'b0;
    cyc(); #1;
    chk16("tie_c9_addr", mem_addr_1, 16'h0044);

    // Fairness, WAIT=0: both requesting continuously
    do_reset();
    cpu_rd = 1'b1; cpu_addr = 16'h0A00;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0B00;
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      chk1 ("fair_en",   mem_en_0,   1'b1);
      chk16("fair_addr", mem_addr_0, (k % 2 == 0) ? 16'h0A00 : 16'h0B00);
      cyc(); #1;
      chk1("fair_ack",   dma_ack_0,   (k % 2 == 1));
      chk1("fair_stall", cpu_stall_0, (k % 2 == 1));
      cyc();
    end

    // Reset mid-access, WAIT=3
    do_reset();
    cpu_rd = 1'b1; cpu_addr = 16'h0700; mem_rdata = 16'h7777;
    repeat (5) cyc();
    #1;
    chk16("mr_cpu_rdata", cpu_rdata_3, 16'h7777);
    cyc();
    cpu_rd = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0600; mem_rdata = 16'h8888;
    repeat (5) cyc();
    #1;
    chk1 ("mr_dma_ack",   dma_ack_3,   1'b1);
    chk16("mr_dma_rdata", dma_rdata_3, 16'h8888);
    cyc();
    dma_req = 1'b0;
    cpu_wr = 1'b1; cpu_addr = 16'h0710; cpu_wdata = 16'h5555;
    cyc(); #1;
    chk1("mr_c1_en", mem_en_3, 1'b1);
    chk1("mr_c1_we", mem_we_3, 1'b1);
    RSTn = 1'b0;
    #1;
    chk1 ("mr_rst_en",    mem_en_3,    1'b0);
    chk1 ("mr_rst_we",    mem_we_3,    1'b0);
    chk16("mr_rst_addr",  mem_addr_3,  16'h0000);
    chk16("mr_rst_wdata", mem_wdata_3, 16'h0000);
    chk1 ("mr_rst_busy",  busy_3,      1'b0);
    chk1 ("mr_rst_ack",   dma_ack_3,   1'b0);
    chk16("mr_rst_cpu",   cpu_rdata_3, 16'h0000);
    chk16("mr_rst_dma",   dma_rdata_3, 16'h0000);
    chk1 ("mr_rst_stall", cpu_stall_3, 1'b1);
    cpu_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk1("mr_hold_ack", dma_ack_3, 1'b0);
    end
    RSTn = 1'b1;
    cpu_rd = 1'b1; cpu_addr = 16'h0720;
    dma_req = 1'b1; dma_addr = 16'h0620;
    cyc(); #1;
    chk16("mr_tie_addr", mem_addr_3, 16'h0720);

    // DMA request dropped after grant, WAIT=1
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0800; dma_wdata = 16'h9999;
    cyc();
    dma_req = 1'b0;
    #1;
    chk1 ("dd_c1_en",   mem_en_1,   1'b1);
    chk16("dd_c1_addr", mem_addr_1, 16'h0800);
    cyc(); #1;
    chk1("dd_c2_ack", dma_ack_1, 1'b0);
    chk1("dd_c2_en",  mem_en_1,  1'b1);
    cyc(); #1;
    chk1("dd_c3_ack", dma_ack_1, 1'b1);
    cyc(); #1;
    chk1("dd_c4_ack",  dma_ack_1, 1'b0);
    chk1("dd_c4_busy", busy_1,    1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port memory-bus arbiter and access sequencer sitting between the CPU datapath, a DMA/peripheral master and the single-port data memory. It serialises CPU bus reads and writes (driven by the control unit's Rbus/Wbus strobes) against DMA requests. Each access takes a fixed number of memory wait states, and the block stalls the CPU until its access completes. Round-robin arbitration on simultaneous requests prevents either master from starving the other.

## Interface
- AW, 16, address width
- DW, 16, data width
- WAIT, 1, extra memory wait cycles per access (0..15)

- CLK  in  1  system clock, rising edge
- RSTn  in  1  asynchronous active-low reset
- cpu_rd  in  1  CPU read request (level, held until cpu_stall low)
- cpu_wr  in  1  CPU write request (level, held until cpu_stall low)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  registered CPU read data
- cpu_stall  out  1  CPU must hold state and request
- dma_req  in  1  DMA request (level, held until dma_ack)
- dma_we  in  1  DMA write (1) / read (0)
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_rdata  out  DW  registered DMA read data
- dma_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, combinationally valid in final ACCESS cycle
- busy  out  1  FSM not in IDLE

## Operation
- Request signals: cpu_req = cpu_rd | cpu_wr. If cpu_rd and cpu_wr are both high, the access is a write.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Neither master requesting: stay in IDLE.
  - Otherwise: grant, latch owner, address, we and wdata, clear wait counter, go to ACCESS.
- Grant rule:
  - One requester: that requester wins.
  - Both requesting: the master that is not last_owner wins.
  - last_owner updates on every grant. Reset value is DMA, so the CPU wins the first tie.
- ACCESS:
  - mem_en=1. mem_we, mem_addr and mem_wdata come from the latched values, stable for the whole state.
  - Counter increments each cycle. When counter==WAIT, go to RESP.
  - On that exit edge, if the access is a read, capture mem_rdata into the owner's rdata register.
- RESP:
  - mem_en=0.
  - Owner DMA: dma_ack=1 for this cycle only. Owner CPU: cpu_stall is released (see below).
  - Always return to IDLE; there is no RESP->ACCESS shortcut.
- cpu_stall = cpu_req & ~(state==RESP & owner==CPU). This is combinational from cpu_rd/cpu_wr, so it is asserted in the same cycle a CPU request appears.
- Unwritten rdata registers hold their value until the next completed read by the same port. Writes never modify rdata.
- Request changes after grant:
  - Requests deasserted after grant do not abort the access; it completes and ack/stall release still occur.
  - Address or data changes after grant are ignored because the values are latched.
- Outputs while not in ACCESS: mem_we, mem_addr and mem_wdata are don't-care; the bench checks them only when mem_en=1.

## Timing
- Reset (async, RSTn low), applied immediately, including mid-access:
  - FSM to IDLE, counter 0, last_owner=DMA.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rdata=0, dma_rdata=0, dma_ack=0, busy=0.
  - cpu_stall stays combinational: high if cpu_req is high.
- Access sequence, with the request first seen in IDLE at cycle 0:
  - ACCESS occupies cycles 1..WAIT+1.
  - RESP is cycle WAIT+2; the result (ack, stall release, rdata valid) is visible in this cycle.
  - IDLE is cycle WAIT+3.
- Throughput: one access per WAIT+3 cycles.
- A losing requester is granted at the next IDLE cycle.
- WAIT=0: ACCESS lasts exactly one cycle.
- The counter is 4 bits wide and never wraps, because it exits at counter==WAIT ≤ 15.

## Test plan
- Single read, WAIT=1: cpu_rd at cycle 0, addr 0x0010, memory returns 0xBEEF.
  - Required: mem_en=1 in cycles 1–2, cpu_stall=1 in cycles 0–2.
  - Required: cpu_stall=0 and cpu_rdata=0xBEEF in cycle 3, busy=0 in cycle 4.
- DMA write, WAIT=0: dma_req=1, dma_we=1, addr 0x0200, data 0x1234.
  - Required: mem_en=mem_we=1 in cycle 1 with addr 0x0200 and data 0x1234.
  - Required: dma_ack pulses only in cycle 2; dma_rdata unchanged.
- Tie after reset, WAIT=1: cpu_rd and dma_req both high at cycle 0.
  - Required: CPU served in cycles 1–2 and released in cycle 3.
  - Required: DMA granted in cycle 4 (even with a new CPU request present), ACCESS in cycles 5–6, dma_ack in cycle 7.
- Fairness: CPU and DMA continuously requesting over 8 accesses.
  - Required: grants strictly alternate CPU, DMA, CPU, …
- Reset mid-access: RSTn low during ACCESS cycle 1, WAIT=3.
  - Required: mem_en=0 in the same cycle; no dma_ack; busy=0; rdata registers read 0.
  - Required: after release, the next tie grants the CPU.
- Request dropped: dma_req deasserted in the first ACCESS cycle.
  - Required: access still completes and dma_ack still pulses in cycle WAIT+2.
